// File: rtl/ex_muldiv_sequencer_if.sv
// Handshake and result bundle between the EX stage and the
// bit-serial multiply/divide sequencer.
interface ex_muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            op_div;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            stall_o;
  logic            done;
  logic [XLEN-1:0] result_lo;
  logic [XLEN-1:0] result_hi;
  logic            div_by_zero;

  modport master (
    output start, op_div, a, b, flush,
    input  stall_o, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op_div, a, b, flush,
    output stall_o, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// Bit-serial unsigned MUL/DIV unit beside the EX-stage ALU.
// One iteration per cycle; stalls IF/ID/EX while running.
module ex_muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ex_muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              div_q, div_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic              dbz_q, dbz_d;

  logic [XLEN:0]     sum;
  logic [XLEN:0]     remx;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] mul_nxt;
  logic [2*XLEN-1:0] div_nxt;
  logic [2*XLEN-1:0] step;

  // acc holds {hi, multiplier} for MUL and {rem, quot} for DIV
  always_comb begin
    sum     = {1'b0, acc_q[2*XLEN-1:XLEN]}
            + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt = {sum, acc_q[XLEN-1:1]};
    // remx keeps the bit shifted out of rem so large divisors work
    remx    = acc_q[2*XLEN-1:XLEN-1];
    diff    = remx - {1'b0, opnd_q};
    div_nxt = diff[XLEN]
            ? {remx[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
            : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step    = div_q ? div_nxt : mul_nxt;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          div_d = bus.op_div;
          cnt_d = '0;
          dbz_d = 1'b0;
          if (bus.op_div && bus.b == '0) begin
            state_d = DONE;
            lo_d    = '1;
            hi_d    = bus.a;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            opnd_d  = bus.op_div ? bus.b : bus.a;
            acc_d   = {{XLEN{1'b0}},
                       bus.op_div ? bus.a : bus.b};
          end
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d = DONE;
            lo_d    = step[XLEN-1:0];
            hi_d    = step[2*XLEN-1:XLEN];
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.stall_o     = (state_q == IDLE && bus.start && !bus.flush)
                         || state_q == RUN;
  assign bus.done        = state_q == DONE;
  assign bus.result_lo   = lo_q;
  assign bus.result_hi   = hi_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed-vector bench for ex_muldiv_sequencer.
// Table of ops plus hand sequences for flush/reset corners.
module tb_ex_muldiv_sequencer;

  logic clk;
  logic rst_n;

  ex_muldiv_sequencer_if #(.XLEN(32)) bus ();

  ex_muldiv_sequencer #(
    .XLEN (32),
    .CNT_W(6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Launch one op; returns edges-to-done (sampling edge
  // counted as 1), stall cycles seen and the results.
  task automatic do_op(input logic div,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       output int lat,
                       output int stalls,
                       output logic [31:0] lo,
                       output logic [31:0] hi,
                       output logic dbz);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_div = div;
    bus.a      = x;
    bus.b      = y;
    #1;
    stalls = int'(bus.stall_o);
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (bus.done || lat >= 100) break;
      stalls += int'(bus.stall_o);
      @(posedge clk);
      lat++;
    end
    lo  = bus.result_lo;
    hi  = bus.result_hi;
    dbz = bus.div_by_zero;
    chk("stall_in_done", {63'd0, bus.stall_o}, 64'd0);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, bus.done}, 64'd0);
  endtask

  int          lat, stl;
  logic [31:0] lo, hi;
  logic        dbz;
  logic [31:0] hold_lo, hold_hi;

  initial begin
    vecs[0]  = '{1'b0, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0, 33};
    vecs[1]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'h00000001, 32'hFFFFFFFE, 1'b0, 33};
    vecs[2]  = '{1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33};
    vecs[3]  = '{1'b1, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33};
    vecs[4]  = '{1'b1, 32'd123, 32'd0,
                 32'hFFFFFFFF, 32'd123, 1'b1, 1};
    vecs[5]  = '{1'b0, 32'h10000, 32'h10000, 32'd0, 32'd1, 1'b0, 33};
    vecs[6]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE,
                 32'd1, 32'd1, 1'b0, 33};
    vecs[7]  = '{1'b1, 32'hFFFFFFFF, 32'd1,
                 32'hFFFFFFFF, 32'd0, 1'b0, 33};
    vecs[8]  = '{1'b0, 32'h12345678, 32'd0, 32'd0, 32'd0, 1'b0, 33};
    vecs[9]  = '{1'b0, 32'h12345678, 32'h10,
                 32'h23456780, 32'h1, 1'b0, 33};
    vecs[10] = '{1'b1, 32'hDEADBEEF, 32'h10000,
                 32'hDEAD, 32'hBEEF, 1'b0, 33};
    vecs[11] = '{1'b1, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 33};

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op_div = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.flush  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_stall", {63'd0, bus.stall_o}, 64'd0);
    chk("rst_lo", {32'd0, bus.result_lo}, 64'd0);
    chk("rst_hi", {32'd0, bus.result_hi}, 64'd0);
    chk("rst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].div, vecs[i].a, vecs[i].b, lat, stl, lo, hi, dbz);
      chk($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
      chk($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
      chk($sformatf("v%0d_dbz", i), {63'd0, dbz}, {63'd0, vecs[i].dbz});
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_stall", i), 64'(stl), 64'(vecs[i].lat));
    end

    // flush at iteration 10 leaves results intact
    hold_lo = vecs[11].lo;
    hold_hi = vecs[11].hi;
    @(negedge clk);
    bus.start = 1'b1; bus.op_div = 1'b0;
    bus.a = 32'd3; bus.b = 32'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("flush_pre_stall", {63'd0, bus.stall_o}, 64'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("flush_stall", {63'd0, bus.stall_o}, 64'd0);
      chk("flush_done", {63'd0, bus.done}, 64'd0);
      chk("flush_lo", {32'd0, bus.result_lo}, {32'd0, hold_lo});
      chk("flush_hi", {32'd0, bus.result_hi}, {32'd0, hold_hi});
    end
    do_op(1'b0, 32'd3, 32'd5, lat, stl, lo, hi, dbz);
    chk("post_flush_lo", {32'd0, lo}, 64'd15);
    chk("post_flush_lat", 64'(lat), 64'd33);

    // start together with flush in IDLE is refused
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1;
    bus.op_div = 1'b1; bus.a = 32'd9; bus.b = 32'd0;
    #1 chk("sf_stall", {63'd0, bus.stall_o}, 64'd0);
    @(posedge clk);
    #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
    @(negedge clk);
    chk("sf_done", {63'd0, bus.done}, 64'd0);
    chk("sf_stall2", {63'd0, bus.stall_o}, 64'd0);
    chk("sf_lo", {32'd0, bus.result_lo}, 64'd15);

    // flush during DONE does not cancel the pulse
    @(negedge clk);
    bus.start = 1'b1; bus.op_div = 1'b1;
    bus.a = 32'd9; bus.b = 32'd0;
    @(posedge clk);
    #1 begin bus.start = 1'b0; bus.flush = 1'b1; end
    @(negedge clk);
    chk("fd_done", {63'd0, bus.done}, 64'd1);
    chk("fd_hi", {32'd0, bus.result_hi}, 64'd9);
    @(posedge clk);
    #1 bus.flush = 1'b0;

    // async reset mid-RUN
    @(negedge clk);
    bus.start = 1'b1; bus.op_div = 1'b0;
    bus.a = 32'd7; bus.b = 32'd6;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("mid_stall", {63'd0, bus.stall_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_stall", {63'd0, bus.stall_o}, 64'd0);
    chk("arst_done", {63'd0, bus.done}, 64'd0);
    chk("arst_lo", {32'd0, bus.result_lo}, 64'd0);
    chk("arst_hi", {32'd0, bus.result_hi}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b1, 32'd100, 32'd7, lat, stl, lo, hi, dbz);
    chk("rr_lo", {32'd0, lo}, 64'd14);
    chk("rr_hi", {32'd0, hi}, 64'd2);
    chk("rr_lat", 64'(lat), 64'd33);
    do_op(1'b0, 32'd7, 32'd6, lat, stl, lo, hi, dbz);
    chk("b2b_lo", {32'd0, lo}, 64'd42);
    chk("b2b_lat", 64'(lat), 64'd33);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
